sr_flag_ctrl: RTL and testbench
===============================

# sr_flag_ctrl

Controller that shares one bank of SR-flip-flop status flags between several requesters. Each cycle a round-robin arbiter grants at most one set or clear request and drives exactly one of s or r to the addressed flag, so the illegal s=r=1 combination can never reach a cell. A flush command sequences a one-flag-per-cycle clear of the whole bank. The block sits between the status-producing engines and the flag bank, which other logic reads directly.

## Interface
- NREQ, 4, number of requesters (2..8)
- NFLAG, 8, number of flags in the bank (2..64)
- FW, $clog2(NFLAG), flag index width (derived; not overridden)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_op  in  NREQ  per-requester op: 1 = set, 0 = clear
- req_idx  in  NREQ*FW  per-requester flag index; requester k uses bits [k*FW +: FW]
- req_ready  out  NREQ  one-hot grant; the request is consumed in the cycle where valid and ready are both high
- flush_req  in  1  request to clear all flags
- flush_done  out  1  one-cycle pulse when the flush completes
- busy  out  1  high while in FLUSH
- idx_err  out  1  one-cycle pulse, registered, when a granted idx is >= NFLAG
- flag_q  out  NFLAG  flag bank outputs

## Operation
- FSM states: IDLE, SERVE, FLUSH.
  - IDLE -> SERVE when any req_valid is high and flush_req is low.
  - IDLE or SERVE -> FLUSH when flush_req is high; flush takes priority, and there is no grant that cycle.
  - SERVE -> IDLE when no req_valid is high.
  - FLUSH -> IDLE after the clear of index NFLAG-1.
- Arbitration, in IDLE and SERVE:
  - The grant is combinational from req_valid and the registered pointer ptr.
  - Pick the first valid requester found searching ptr, ptr+1, ... with wrap mod NREQ.
  - After a grant to requester g, ptr <= (g+1) mod NREQ. With no grant, ptr is unchanged.
- Flag drive:
  - A granted set drives s=1 to flag idx.
  - A granted clear drives r=1 to flag idx.
  - All other cells get s=r=0 and hold.
  - Redundant ops, such as setting a flag that is already set, are still granted and consume the slot.
- Out-of-range idx (>= NFLAG): the request is granted and consumed, no flag changes, and idx_err pulses the next cycle.
- Flush:
  - Counter cnt runs 0..NFLAG-1 and drives r=1 to flag cnt, one flag per cycle.
  - req_ready is all zero throughout.
  - flush_req during FLUSH is ignored.
  - flush_done pulses on the cycle after the last clear, in IDLE.
- Requesters may hold valid with fixed op/idx across cycles. Changing a request while it is stalled is legal, and the value sampled at grant wins.

## Timing
- Reset values:
  - flag_q = 0, ptr = 0, state IDLE, cnt = 0.
  - req_ready = 0, busy = 0, flush_done = 0, idx_err = 0.
- Reset asserted mid-flush or mid-serve returns everything to the reset values immediately, asynchronously. No flush_done is produced.
- Grant latency is 0 cycles: req_ready rises in the same cycle as req_valid when that requester wins.
- Flag update latency: flag_q reflects the granted op 1 cycle after the handshake cycle.
- Throughput is one op per cycle overall. Any continuously valid requester is granted within NREQ cycles.
- Flush duration:
  - flush_req is sampled at edge T, and the FSM enters FLUSH at T+1.
  - Flag k clears at the edge ending FLUSH cycle k.
  - busy is high for NFLAG cycles.
  - flush_done is high in cycle T+1+NFLAG.
- Two requesters targeting the same flag with opposite ops in the same cycle: only the round-robin winner acts. The loser is served in a later cycle, and its op is the final value.

## Structure
- Package sr_flag_pkg:
  - op encoding constants OP_CLR=1'b0, OP_SET=1'b1
  - state enum type (IDLE, SERVE, FLUSH)
- Sub-module sr_flag_cell, instantiated NFLAG times:
  - single SR flip-flop, ports clk, rst, s, r, q
  - async active-high reset to 0; 00 holds, 01 clears, 10 sets
  - the controller guarantees 11 never occurs, and the cell asserts this in simulation
- Top level holds the arbiter, ptr, FSM, flush counter and the s/r decode.

## Test plan
- Reset: assert rst mid-stream with flags at 8'hA5 -> flag_q=0, req_ready=0 and busy=0 asynchronously. After release, ptr=0, so requester 0 wins the first contention.
- Single op: req 2 sets idx 5 -> req_ready=4'b0100 the same cycle and flag_q=8'h20 the next cycle. Then req 2 clears idx 5 -> flag_q=0.
- Round-robin: all 4 valid continuously, setting idx 0..3 respectively -> grants 0,1,2,3,0 on consecutive cycles and flag_q=8'h0F after 4 grants.
- Conflict: with ptr=0, req 0 sets idx 3 and req 1 clears idx 3 in the same cycle -> req 0 granted first, then req 1. Final flag_q[3]=0, and it is never X.
- Flush: flag_q=8'hFF, pulse flush_req while req 1 is valid -> no grant that cycle. busy is high for 8 cycles, flags clear in order bit0..bit7, and flush_done pulses once. Req 1 is granted in the cycle after flush_done.
- Error: NFLAG=6 and req 0 with idx 7 -> granted, idx_err pulses the next cycle, and flag_q is unchanged.

Source files
------------

// File: rtl/sr_flag_pkg.sv
// Shared encodings for the SR flag controller: request op codes and FSM states.
package sr_flag_pkg;
    localparam logic OP_CLR = 1'b0;
    localparam logic OP_SET = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        FLUSH = 2'd2
    } state_e;
endpackage

// File: rtl/sr_flag_ctrl_if.sv
// Requester/flag-bank bundle; master = requester side, slave = controller.
interface sr_flag_ctrl_if #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8
);
    localparam int FW = $clog2(NFLAG);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_op;
    logic [NREQ*FW-1:0] req_idx;
    logic [NREQ-1:0]    req_ready;
    logic               flush_req;
    logic               flush_done;
    logic               busy;
    logic               idx_err;
    logic [NFLAG-1:0]   flag_q;

    modport master (
        output req_valid, req_op, req_idx, flush_req,
        input  req_ready, flush_done, busy, idx_err, flag_q
    );

    modport slave (
        input  req_valid, req_op, req_idx, flush_req,
        output req_ready, flush_done, busy, idx_err, flag_q
    );
endinterface

// File: rtl/sr_flag_cell.sv
// Single SR flip-flop status flag; 00 holds, 01 clears, 10 sets.
module sr_flag_cell (
    input  logic clk,
    input  logic rst,
    input  logic s,
    input  logic r,
    output logic q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= 1'b0;
        else if (s)
            q <= 1'b1;
        else if (r)
            q <= 1'b0;
    end

    a_no_set_and_reset: assert property (@(posedge clk) disable iff (rst) !(s && r));
endmodule

// File: rtl/sr_flag_ctrl.sv
// Round-robin arbiter driving one SR flag per cycle, plus a sequential bank flush.
module sr_flag_ctrl
    import sr_flag_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8
) (
    input  logic         clk,
    input  logic         rst,
    sr_flag_ctrl_if.slave bus
);
    localparam int FW = $clog2(NFLAG);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [FW-1:0]   cnt_q, cnt_d;
    logic            idx_err_q, idx_err_d;
    logic            done_q, done_d;

    logic            found;
    logic [PW-1:0]   win, cand;
    logic            grant_en, hs, last_cnt, sel_op;
    logic [FW-1:0]   sel_idx;
    logic [NFLAG-1:0] s_v, r_v, q_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            idx_err_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            idx_err_q <= idx_err_d;
            done_q    <= done_d;
        end
    end

    // Search ptr, ptr+1, ... (mod NREQ) for the first valid requester.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = PW'((int'(ptr_q) + i) % NREQ);
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        sel_op  = bus.req_op[win];
        sel_idx = bus.req_idx[win*FW +: FW];
    end

    // The flush completion cycle is reserved for flush_done; grants resume after it.
    assign grant_en = !rst && (state_q != FLUSH) && !bus.flush_req && !done_q;
    assign hs       = grant_en && found;
    assign last_cnt = (cnt_q == FW'(NFLAG - 1));

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = '0;
        idx_err_d = hs && (int'(sel_idx) >= NFLAG);
        done_d    = 1'b0;
        if (hs)
            ptr_d = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
        case (state_q)
            IDLE: begin
                if (bus.flush_req)
                    state_d = FLUSH;
                else if (|bus.req_valid)
                    state_d = SERVE;
            end
            SERVE: begin
                if (bus.flush_req)
                    state_d = FLUSH;
                else if (!(|bus.req_valid))
                    state_d = IDLE;
            end
            FLUSH: begin
                cnt_d = last_cnt ? '0 : cnt_q + 1'b1;
                if (last_cnt) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        if (hs)
            bus.req_ready[win] = 1'b1;
        bus.busy       = (state_q == FLUSH);
        bus.flush_done = done_q;
        bus.idx_err    = idx_err_q;
        bus.flag_q     = q_v;
    end

    generate
        for (genvar gi = 0; gi < NFLAG; gi++) begin : g_cell
            assign s_v[gi] = hs && (sel_op == OP_SET) && (sel_idx == FW'(gi));
            assign r_v[gi] = (hs && (sel_op == OP_CLR) && (sel_idx == FW'(gi)))
                           || ((state_q == FLUSH) && (cnt_q == FW'(gi)));
            sr_flag_cell u_cell (
                .clk (clk),
                .rst (rst),
                .s   (s_v[gi]),
                .r   (r_v[gi]),
                .q   (q_v[gi])
            );
        end
    endgenerate
endmodule

// File: tb/tb_sr_flag_ctrl.sv
// Directed bench for sr_flag_ctrl: an 8-flag instance plus a 6-flag one for index errors.
module tb_sr_flag_ctrl;
    import sr_flag_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;
    logic [7:0] exp8;

    always #5 clk = ~clk;

    sr_flag_ctrl_if #(.NREQ(4), .NFLAG(8)) i8 ();
    sr_flag_ctrl_if #(.NREQ(4), .NFLAG(6)) i6 ();

    sr_flag_ctrl #(.NREQ(4), .NFLAG(8)) dut8 (.clk(clk), .rst(rst), .bus(i8));
    sr_flag_ctrl #(.NREQ(4), .NFLAG(6)) dut6 (.clk(clk), .rst(rst), .bus(i6));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic set8(input int k, input logic v, input logic op, input int idx);
        logic [31:0] iv;
        iv = idx;
        i8.req_valid[k]     = v;
        i8.req_op[k]        = op;
        i8.req_idx[k*3 +: 3] = iv[2:0];
    endtask

    task automatic set6(input int k, input logic v, input logic op, input int idx);
        logic [31:0] iv;
        iv = idx;
        i6.req_valid[k]     = v;
        i6.req_op[k]        = op;
        i6.req_idx[k*3 +: 3] = iv[2:0];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        i8.req_valid = '0; i8.req_op = '0; i8.req_idx = '0; i8.flush_req = 1'b0;
        i6.req_valid = '0; i6.req_op = '0; i6.req_idx = '0; i6.flush_req = 1'b0;

        #2;
        check("rst_flag", i8.flag_q, 8'h00);
        check("rst_ready", i8.req_ready, 4'b0000);
        check("rst_busy", i8.busy, 1'b0);
        check("rst_done", i8.flush_done, 1'b0);
        check("rst_err", i8.idx_err, 1'b0);
        @(negedge clk); rst = 1'b0;

        // single op: req 2 sets then clears flag 5
        @(negedge clk); set8(2, 1'b1, OP_SET, 5);
        #1 check("single_ready", i8.req_ready, 4'b0100);
        @(negedge clk); set8(2, 1'b1, OP_CLR, 5);
        #1 check("single_set", i8.flag_q, 8'h20);
        check("single_ready2", i8.req_ready, 4'b0100);
        @(negedge clk); set8(2, 1'b0, OP_CLR, 0);
        #1 check("single_clr", i8.flag_q, 8'h00);
        check("single_idle", i8.req_ready, 4'b0000);

        // build 8'hA5 with requester 0, then reset mid-stream
        @(negedge clk); set8(0, 1'b1, OP_SET, 0);
        @(negedge clk); set8(0, 1'b1, OP_SET, 2);
        @(negedge clk); set8(0, 1'b1, OP_SET, 5);
        @(negedge clk); set8(0, 1'b1, OP_SET, 7);
        @(negedge clk); set8(0, 1'b0, OP_SET, 0);
        #1 check("build_a5", i8.flag_q, 8'hA5);
        @(negedge clk); set8(1, 1'b1, OP_SET, 0);
        #1 check("pre_rst_ready", i8.req_ready, 4'b0010);
        #1 rst = 1'b1;
        #1 check("async_rst_flag", i8.flag_q, 8'h00);
        check("async_rst_ready", i8.req_ready, 4'b0000);
        check("async_rst_busy", i8.busy, 1'b0);
        @(negedge clk); set8(1, 1'b0, OP_SET, 0);
        @(negedge clk); rst = 1'b0;

        // round robin from ptr = 0
        @(negedge clk);
        for (int k = 0; k < 4; k++) set8(k, 1'b1, OP_SET, k);
        #1 check("rr_g0", i8.req_ready, 4'b0001);
        @(negedge clk); #1 check("rr_g1", i8.req_ready, 4'b0010);
        @(negedge clk); #1 check("rr_g2", i8.req_ready, 4'b0100);
        @(negedge clk); #1 check("rr_g3", i8.req_ready, 4'b1000);
        @(negedge clk); #1 check("rr_g0b", i8.req_ready, 4'b0001);
        check("rr_flags", i8.flag_q, 8'h0F);
        @(negedge clk);
        for (int k = 0; k < 4; k++) set8(k, 1'b0, OP_SET, 0);

        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        #1 check("rst2_flag", i8.flag_q, 8'h00);

        // conflict on flag 3: req 0 sets, req 1 clears
        @(negedge clk); set8(0, 1'b1, OP_SET, 3); set8(1, 1'b1, OP_CLR, 3);
        #1 check("conf_first", i8.req_ready, 4'b0001);
        @(negedge clk); set8(0, 1'b0, OP_SET, 0);
        #1 check("conf_second", i8.req_ready, 4'b0010);
        check("conf_mid", i8.flag_q, 8'h08);
        @(negedge clk); set8(1, 1'b0, OP_SET, 0);
        #1 check("conf_final", i8.flag_q, 8'h00);

        // flush from all-ones while req 1 is waiting
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); set8(0, 1'b1, OP_SET, k);
        end
        @(negedge clk); set8(0, 1'b0, OP_SET, 0);
        #1 check("flush_pre", i8.flag_q, 8'hFF);
        @(negedge clk); i8.flush_req = 1'b1; set8(1, 1'b1, OP_CLR, 4);
        #1 check("flush_nogrant", i8.req_ready, 4'b0000);
        check("flush_req_busy", i8.busy, 1'b0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); i8.flush_req = (k == 3);
            exp8 = 8'hFF << k;
            #1 check($sformatf("flush_busy%0d", k), i8.busy, 1'b1);
            check($sformatf("flush_ready%0d", k), i8.req_ready, 4'b0000);
            check($sformatf("flush_flag%0d", k), i8.flag_q, exp8);
            check($sformatf("flush_nodone%0d", k), i8.flush_done, 1'b0);
        end
        @(negedge clk);
        #1 check("flush_done", i8.flush_done, 1'b1);
        check("flush_end_busy", i8.busy, 1'b0);
        check("flush_end_ready", i8.req_ready, 4'b0000);
        check("flush_end_flag", i8.flag_q, 8'h00);
        @(negedge clk);
        #1 check("flush_done_once", i8.flush_done, 1'b0);
        check("flush_resume", i8.req_ready, 4'b0010);
        @(negedge clk); set8(1, 1'b0, OP_SET, 0);

        // out-of-range index on the 6-flag instance
        @(negedge clk); set6(0, 1'b1, OP_SET, 5);
        #1 check("err_ok_ready", i6.req_ready, 4'b0001);
        @(negedge clk); set6(0, 1'b1, OP_SET, 6);
        #1 check("err_set5", i6.flag_q, 6'h20);
        check("err_idx6_ready", i6.req_ready, 4'b0001);
        check("err_none", i6.idx_err, 1'b0);
        @(negedge clk); set6(0, 1'b1, OP_CLR, 7);
        #1 check("err_idx6", i6.idx_err, 1'b1);
        check("err_idx6_flag", i6.flag_q, 6'h20);
        check("err_idx7_ready", i6.req_ready, 4'b0001);
        @(negedge clk); set6(0, 1'b0, OP_SET, 0);
        #1 check("err_idx7", i6.idx_err, 1'b1);
        check("err_idx7_flag", i6.flag_q, 6'h20);
        @(negedge clk);
        #1 check("err_clear", i6.idx_err, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
